// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch clock path (divider and tick recovery).
// Contents: lock-tracking state enum, system clock rate and nominal
// half-period of the divided 100 Hz clock in system clock cycles.
package stopwatch_pkg;

  localparam int CLK_HZ            = 50_000_000;
  localparam int HALF_PERIOD_100HZ = 250000;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/tick_recover_100hz_if.sv
// Bundle between the divided-clock source, the tick recovery block and its
// consumers.
//   clk_100Hz_in  : divided clock into the recovery block
//   tick_rise     : one-cycle strobe per rising edge
//   tick_any      : one-cycle strobe per edge of either polarity
//   locked        : input period currently within tolerance
//   err_pulse     : one-cycle strobe per bad interval or timeout
//   err_count     : saturating error count since reset
//   last_interval : most recent edge-to-edge interval in system cycles
// slave  = the recovery block, master = source / consumer side.
interface tick_recover_100hz_if #(
  parameter int CNT_W = 19
);
  logic             clk_100Hz_in;
  logic             tick_rise;
  logic             tick_any;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] last_interval;

  modport slave (
    input  clk_100Hz_in,
    output tick_rise, tick_any, locked, err_pulse, err_count, last_interval
  );

  modport master (
    output clk_100Hz_in,
    input  tick_rise, tick_any, locked, err_pulse, err_count, last_interval
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous slow clock into the system domain and emits
// registered edge strobes.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   din      : asynchronous input
//   rise     : one-cycle strobe per rising edge of the synchronised input
//   edge_any : one-cycle strobe per edge of either polarity
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic edge_any
);

  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [2:0]             warm_q;
  logic                   sync;
  logic                   warm_done;

  assign sync      = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_CYCLES);

  // Until the chain and prev have been flushed with the live input, any
  // difference is just the reset value leaking through, so strobes are
  // masked; a high input at release therefore never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      warm_q   <= '0;
      rise     <= 1'b0;
      edge_any <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q   <= sync;
      if (!warm_done) warm_q <= warm_q + 3'd1;
      rise     <= warm_done & sync & ~prev_q;
      edge_any <= warm_done & (sync ^ prev_q);
    end
  end

endmodule

// File: rtl/tick_recover_100hz.sv
// Recovers tick enables from the divided 100 Hz clock and tracks its health.
//   CLK_50_MHz : system clock (only clock)
//   reset      : asynchronous active-high reset
//   bus        : slave side of tick_recover_100hz_if (input clock, ticks,
//                lock/error status, last measured interval)
//
// state    | meaning
// UNLOCKED | no reference edge yet (or lost after timeout); nothing judged
// ACQUIRE  | counting consecutive good intervals towards lock
// LOCKED   | input within tolerance; a bad interval drops back to ACQUIRE
module tick_recover_100hz
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HALF_PERIOD = HALF_PERIOD_100HZ,
  parameter int TOL         = 4,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 19
) (
  input  logic                 CLK_50_MHz,
  input  logic                 reset,
  tick_recover_100hz_if.slave  bus
);

  localparam logic [CNT_W-1:0] IV_MIN  = CNT_W'(HALF_PERIOD - TOL);
  localparam logic [CNT_W-1:0] IV_MAX  = CNT_W'(HALF_PERIOD + TOL);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam int               GOOD_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  logic              rise_s;
  logic              edge_s;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  last_q;
  lock_state_t       state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              err_d, err_q;
  logic [7:0]        errc_q;
  logic              locked_q;
  logic              iv_good;
  logic              timeout;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (CLK_50_MHz),
    .rst      (reset),
    .din      (bus.clk_100Hz_in),
    .rise     (rise_s),
    .edge_any (edge_s)
  );

  assign iv_good = (cnt_q >= IV_MIN) && (cnt_q <= IV_MAX);
  assign timeout = (cnt_q > IV_MAX);

  // Edge evaluation takes priority over timeout, so a late edge arriving in
  // the same cycle as the timeout is judged as a bad interval, not a stall.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    if (edge_s) begin
      case (state_q)
        UNLOCKED: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          if (iv_good) begin
            good_d = good_q + 1'b1;
            if (good_d == GOOD_LOCK) state_d = LOCKED;
          end else begin
            good_d = '0;
            err_d  = 1'b1;
          end
        end
        LOCKED: begin
          if (!iv_good) begin
            state_d = ACQUIRE;
            good_d  = '0;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = UNLOCKED;
          good_d  = '0;
        end
      endcase
    end else if ((state_q != UNLOCKED) && timeout) begin
      state_d = UNLOCKED;
      good_d  = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK_50_MHz or posedge reset) begin
    if (reset) begin
      state_q  <= UNLOCKED;
      good_q   <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      err_q    <= 1'b0;
      errc_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= (state_d == LOCKED);
      if (err_d && (errc_q != 8'hFF)) errc_q <= errc_q + 8'd1;
      if (edge_s) begin
        last_q <= cnt_q;
        cnt_q  <= CNT_W'(1);
      end else if (cnt_q != CNT_SAT) begin
        cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.tick_rise     = rise_s;
  assign bus.tick_any      = edge_s;
  assign bus.locked        = locked_q;
  assign bus.err_pulse     = err_q;
  assign bus.err_count     = errc_q;
  assign bus.last_interval = last_q;

endmodule

// File: tb/tb_tick_recover_100hz.sv
// Bench for tick_recover_100hz: builds sampled waveforms, derives expected
// tick/error/interval/lock events from them up front, then a monitor compares
// the DUT outputs against those queued events cycle by cycle.
module tb_tick_recover_100hz;

  localparam int S   = 2;
  localparam int H   = 3;
  localparam int T   = 0;
  localparam int LC  = 4;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tick_recover_100hz_if #(.CNT_W(CW)) bus ();

  tick_recover_100hz #(
    .SYNC_STAGES (S),
    .HALF_PERIOD (H),
    .TOL         (T),
    .LOCK_COUNT  (LC),
    .CNT_W       (CW)
  ) dut (
    .CLK_50_MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t tick_q[$];
  ev_t err_q[$];
  ev_t li_q[$];
  ev_t lk_q[$];
  int  w[$];
  int  cur;
  int  errors = 0;
  int  checks = 0;
  int  pcount = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) pcount <= 0;
    else       pcount <= pcount + 1;
  end

  // Monitor: compare whatever the DUT presents against the queued events.
  always @(negedge clk) begin
    bit  exp_t;
    bit  exp_e;
    ev_t ev;
    if (mon_en && !reset && pcount > 0) begin
      exp_t = (tick_q.size() > 0) && (tick_q[0].cyc == pcount);
      if (exp_t || bus.tick_any) begin
        checks++;
        if (!exp_t) begin
          errors++;
          $display("FAIL tick_any cycle %0d: got 1 want 0", pcount);
        end else begin
          ev = tick_q.pop_front();
          if (!bus.tick_any) begin
            errors++;
            $display("FAIL tick_any cycle %0d: got 0 want 1", pcount);
          end else if (bus.tick_rise != (ev.val != 0)) begin
            errors++;
            $display("FAIL tick_rise cycle %0d: got %0b want %0b", pcount, bus.tick_rise, ev.val != 0);
          end
        end
      end else if (bus.tick_rise) begin
        checks++;
        errors++;
        $display("FAIL tick_rise_alone cycle %0d: got 1 want 0", pcount);
      end

      exp_e = (err_q.size() > 0) && (err_q[0].cyc == pcount);
      if (exp_e || bus.err_pulse) begin
        checks++;
        if (!exp_e) begin
          errors++;
          $display("FAIL err_pulse cycle %0d: got 1 want 0", pcount);
        end else begin
          ev = err_q.pop_front();
          if (!bus.err_pulse) begin
            errors++;
            $display("FAIL err_pulse cycle %0d: got 0 want 1", pcount);
          end else if (int'(bus.err_count) != ev.val) begin
            errors++;
            $display("FAIL err_count cycle %0d: got %0d want %0d", pcount, bus.err_count, ev.val);
          end
        end
      end

      if (li_q.size() > 0 && li_q[0].cyc == pcount) begin
        ev = li_q.pop_front();
        checks++;
        if (int'(bus.last_interval) != ev.val) begin
          errors++;
          $display("FAIL last_interval cycle %0d: got %0d want %0d", pcount, bus.last_interval, ev.val);
        end
      end

      if (lk_q.size() > 0 && lk_q[0].cyc == pcount) begin
        ev = lk_q.pop_front();
        checks++;
        if (bus.locked != (ev.val != 0)) begin
          errors++;
          $display("FAIL locked cycle %0d: got %0b want %0b", pcount, bus.locked, ev.val != 0);
        end
      end
    end
  end

  // Waveform builders: w[j] is the input level sampled at posedge j after
  // reset release (w[0] is unused).
  task automatic wave_start(input int lvl, input int lead);
    w.delete();
    w.push_back(0);
    cur = lvl;
    repeat (lead) w.push_back(cur);
  endtask

  task automatic half(input int len);
    repeat (len) w.push_back(cur);
    cur = 1 - cur;
  endtask

  // Reference: a level change between samples j-1 and j (j >= 2) is seen as
  // a tick after posedge j+S and judged by the lock logic at posedge j+S+1;
  // intervals are distances between judgement points, first one measured
  // from release.
  task automatic build_model(input int n);
    int  st, good, dprev, errc, cnt, j, jt;
    bit  e, err, giv;
    ev_t ev;
    st = 0; good = 0; dprev = 1; errc = 0;
    for (int p = 1; p <= n; p++) begin
      jt = p - S;
      if (jt >= 2 && w[jt] != w[jt-1]) begin
        ev.cyc = p; ev.val = w[jt]; tick_q.push_back(ev);
      end
      j   = p - S - 1;
      e   = (j >= 2) && (w[j] != w[j-1]);
      cnt = p - dprev;
      if (cnt > SAT) cnt = SAT;
      err = 1'b0;
      if (e) begin
        ev.cyc = p; ev.val = cnt; li_q.push_back(ev);
        dprev = p;
        giv   = (cnt >= H - T) && (cnt <= H + T);
        if (st == 0) begin
          st = 1; good = 0;
        end else if (st == 1) begin
          if (giv) begin
            good++;
            if (good == LC) st = 2;
          end else begin
            good = 0; err = 1'b1;
          end
        end else if (!giv) begin
          st = 1; good = 0; err = 1'b1;
        end
      end else if (st != 0 && cnt > H + T) begin
        st = 0; err = 1'b1;
      end
      if (err) begin
        if (errc < 255) errc++;
        ev.cyc = p; ev.val = errc; err_q.push_back(ev);
      end
      ev.cyc = p; ev.val = (st == 2); lk_q.push_back(ev);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.tick_rise || bus.tick_any || bus.locked || bus.err_pulse ||
        bus.err_count != 8'd0 || bus.last_interval != '0) begin
      errors++;
      $display("FAIL %s: got rise=%0b any=%0b lock=%0b err=%0b cnt=%0d li=%0d want all 0",
               name, bus.tick_rise, bus.tick_any, bus.locked, bus.err_pulse,
               bus.err_count, bus.last_interval);
    end
  endtask

  task automatic check_empty(input string name, input int sz);
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: got %0d unmatched events want 0", name, sz);
    end
  endtask

  // Run the current waveform from a fresh release, then assert reset
  // mid-stream and confirm the outputs clear immediately.
  task automatic run_segment(input string name);
    int n;
    n = w.size() - 1;
    build_model(n);
    check_all_zero({name, "_in_reset"});
    @(negedge clk); #1;
    bus.clk_100Hz_in = (w[1] != 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int j = 2; j <= n; j++) begin
      @(negedge clk); #1;
      bus.clk_100Hz_in = (w[j] != 0);
    end
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    mon_en = 1'b0;
    check_all_zero({name, "_reset_clear"});
    check_empty({name, "_ticks"},  tick_q.size());
    check_empty({name, "_errs"},   err_q.size());
    check_empty({name, "_ivals"},  li_q.size());
    check_empty({name, "_locked"}, lk_q.size());
    tick_q.delete(); err_q.delete(); li_q.delete(); lk_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.clk_100Hz_in = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    wave_start(0, $urandom_range(1, 4));
    repeat (12) half(3);
    run_segment("ideal");

    wave_start(1, 20);
    run_segment("high_at_release");

    wave_start(0, $urandom_range(1, 3));
    repeat (8) half(3);
    half(5);
    repeat (9) half(3);
    run_segment("stretch");

    wave_start(0, $urandom_range(1, 3));
    repeat (8) half(3);
    half(2);
    repeat (4) half(3);
    run_segment("short");

    wave_start(0, 2);
    repeat (8) half(3);
    repeat (300) w.push_back(cur);
    run_segment("static");

    for (int r = 0; r < 3; r++) begin
      wave_start($urandom_range(0, 1), $urandom_range(1, 5));
      repeat (40) half(($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 3);
      run_segment("random");
    end

    wave_start(0, 1);
    repeat (270) half(2);
    run_segment("saturate");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_recover_100hz.md
Name: tick_recover_100hz

Overview:
- Receiving end of the stopwatch's divided 100 Hz clock.
- Takes the free-running 100 Hz square wave, synchronises it back into the 50 MHz domain and emits single-cycle tick enables.
- Measures every half-period and reports lock and error status, so downstream counters run on CLK_50_MHz with enables instead of a derived clock.

Parameters:
- SYNC_STAGES, 2: synchroniser depth; legal range 2..4.
- HALF_PERIOD, 250000: expected CLK_50_MHz cycles between consecutive edges of the 100 Hz input. The bench uses 3.
- TOL, 4: allowed ± deviation of a measured interval, in cycles.
- LOCK_COUNT, 4: consecutive in-tolerance intervals required to assert lock.
- CNT_W, 19: interval counter width; must satisfy 2^CNT_W-1 > HALF_PERIOD+TOL.

Ports:
- CLK_50_MHz  in  1  system clock; this is the only clock.
- reset  in  1  asynchronous, active-high reset.
- clk_100Hz_in  in  1  divided clock; asynchronous to CLK_50_MHz in the general case.
- tick_rise  out  1  one-cycle pulse per detected rising edge (100 Hz).
- tick_any  out  1  one-cycle pulse per detected edge of either polarity (200 Hz).
- locked  out  1  high while the input period is within tolerance.
- err_pulse  out  1  one-cycle pulse on each bad interval or timeout.
- err_count  out  8  number of errors since reset; saturates at 255.
- last_interval  out  CNT_W  most recently measured edge-to-edge interval.

Behaviour:
- Interface: one clock, CLK_50_MHz; reset is asynchronous and active-high. All flops clear on reset assertion.
- Reset values:
  - All outputs are 0.
  - Synchroniser flops are 0, state is UNLOCKED, warm-up counter is 0.
- Warm-up after reset release:
  - For the first SYNC_STAGES+1 cycles, the previous-sample register tracks the synchronised value and no edges are reported.
  - A high input at release therefore never generates a false tick.
- Edge detection and latency:
  - clk_100Hz_in passes through SYNC_STAGES flops. prev holds the last synchronised value. edge = sync XOR prev; rise = sync AND NOT prev.
  - tick_rise and tick_any are registered outputs.
  - A transition first sampled at clock k produces a tick high during cycle k+SYNC_STAGES+1.
  - Ticks are emitted regardless of lock state.
- Interval counter cnt:
  - On a detected edge: last_interval <= cnt and cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - An ideal input gives last_interval == HALF_PERIOD.
- Good interval: HALF_PERIOD-TOL <= interval <= HALF_PERIOD+TOL.
- State machine:
  - UNLOCKED:
    - First detected edge -> ACQUIRE, good_cnt = 0.
    - Intervals are not judged here and no errors are raised.
  - ACQUIRE, on each edge:
    - Good interval: good_cnt+1. On reaching LOCK_COUNT -> LOCKED, and locked rises in the cycle after the qualifying edge.
    - Bad interval: good_cnt = 0, stay in ACQUIRE, err_pulse.
  - LOCKED:
    - Bad interval -> ACQUIRE, good_cnt = 0, locked drops next cycle, err_pulse.
  - Timeout, checked in ACQUIRE or LOCKED: cnt > HALF_PERIOD+TOL with no edge -> UNLOCKED, err_pulse, locked = 0.
- Simultaneous edge and timeout in the same cycle: the edge evaluation wins. Only one err_pulse is raised and the state goes to ACQUIRE, not UNLOCKED.
- Timeout is raised only once per stall; no further errors occur while in UNLOCKED.
- err_count increments on every err_pulse and holds at 255.
- Reset mid-operation clears everything immediately. The warm-up rule applies again on release.

Decomposition:
- Shared package (stopwatch_pkg) contains:
  - State enum {UNLOCKED, ACQUIRE, LOCKED}.
  - Constants CLK_HZ=50_000_000 and HALF_PERIOD_100HZ=250000, shared with the divider.
- One sub-module, sync_edge_detect:
  - Contains the synchroniser chain, prev register and warm-up suppression.
  - Outputs registered rise and edge strobes.
- Top level holds the interval counter, tolerance compare, FSM and error counter.

Test Plan (HALF_PERIOD=3, TOL=0, LOCK_COUNT=4, SYNC_STAGES=2):
- Ideal wave toggling every 3 cycles -> first tick_rise 3 cycles after the first sampled rise; last_interval=3; locked rises after the 4th good interval post-acquire; err_count stays 0.
- Release reset with clk_100Hz_in held high for 20 cycles -> no tick_rise or tick_any; state remains UNLOCKED.
- After lock, stretch one half-period to 5 cycles:
  - A timeout occurs when cnt reaches 4.
  - Result: err_pulse once, locked=0, state UNLOCKED, err_count=1.
  - Relock only after 1 + 4 good intervals.
- After lock, one half-period of 2 cycles -> err_pulse, locked drops, state ACQUIRE, last_interval=2.
- Hold the input static for 300 cycles after lock -> exactly one err_pulse, err_count=1.
- Force 260 errors -> err_count saturates at 255. Then assert reset mid-stream -> all outputs 0 within the same cycle.
